output_write_arbiter: RTL and testbench
=======================================

Name: output_write_arbiter

Overview:
- Shares the single output-buffer write port among NUM_REQ per-filter output writers.
- Each writer raises req when its result is done and holds its data. The arbiter grants one writer at a time, round-robin.
- The arbiter waits for the buffer to be ready, issues a one-cycle write at an auto-incrementing address, and stalls all waiting writers.
- Sits between the PE-side write controllers and the output buffer. Cleared per tile by the top controller.

Parameters:
- NUM_REQ, 4, number of requesting writers.
- DATA_W, 16, width of one output word.
- ADDR_W, 6, output buffer address width.
- DEPTH, 64, words per tile before the buffer is full. Must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- clr  input  1  synchronous tile clear: aborts the current transaction and zeroes the address/count.
- req  input  NUM_REQ  per-writer write request; held until gnt is seen in WRITE.
- data_in  input  NUM_REQ*DATA_W  packed writer data; writer i occupies bits [i*DATA_W +: DATA_W].
- buf_ready  input  1  output buffer can accept a write this cycle.
- gnt  output  NUM_REQ  one-hot grant.
- stall  output  NUM_REQ  per-writer pipeline stall.
- wr_en  output  1  buffer write strobe, one cycle.
- wr_addr  output  ADDR_W  buffer write address.
- wr_data  output  DATA_W  buffer write data.
- buf_full  output  1  DEPTH words written since the last clr.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; gnt=0, wr_en=0, wr_addr=0, wr_data=0, buf_full=0, count=0.
  - Round-robin pointer = NUM_REQ-1, so req[0] wins first.
- States: IDLE, ARB, WAIT_RDY, WRITE, RELEASE.
  - IDLE: if |req and !buf_full → ARB; else stay.
  - ARB: pick the first set req bit scanning from ptr+1 upward, wrapping modulo NUM_REQ. Register the one-hot gnt.
    - buf_ready=1 → WRITE.
    - buf_ready=0 → WAIT_RDY.
    - If req dropped to 0 (writer withdrew) → IDLE with gnt=0.
  - WAIT_RDY: hold gnt; go to WRITE when buf_ready=1.
  - WRITE:
    - wr_en=1 for exactly this cycle.
    - wr_data = granted writer's data_in, muxed combinationally from gnt.
    - wr_addr = current count.
    - At the clock edge: count+1, ptr=index of the granted writer → RELEASE.
  - RELEASE: gnt=0, wr_en=0; one dead cycle so the writer can drop req → IDLE.
- Latency: req rising in IDLE with buf_ready=1 gives wr_en exactly 2 cycles later. Minimum spacing between writes is 4 cycles.
- stall:
  - stall[i] = req[i] & !(state==WRITE & gnt[i]).
  - Forced to 0 when clr=1 or buf_full=1 is reached. When full, writers see no stall and are dropped; the top controller is responsible.
- Counter and full flag:
  - count is ADDR_W+1 bits; wr_addr = count[ADDR_W-1:0].
  - buf_full = (count==DEPTH). While full, no new grant occurs and IDLE stays in IDLE.
  - No wrap-around of the address within a tile.
- clr:
  - Highest priority after rst_n, from any state.
  - Effects: state→IDLE, gnt=0, count=0, buf_full=0. ptr is kept.
  - clr in WRITE suppresses wr_en that cycle (wr_en = WRITE & !clr). No write occurs and count is not incremented.
- Simultaneous events:
  - Multiple req in ARB: round-robin decides.
  - A new req arriving during WRITE/RELEASE waits for IDLE.
  - buf_ready falling in WRITE has no effect; it is sampled only in ARB/WAIT_RDY.
- Reset mid-transaction: same as the reset values above; no partial write.

Optional Feature:
- Macro OWA_FIXED_PRIORITY_EN.
- Defined: ARB grants the lowest-index set req. ptr is unused and its logic is removed.
- Undefined: round-robin as specified above.
- Everything else is identical in both builds.

Test Plan:
- Reset then single request:
  - Stimulus: rst_n low 2 cycles; req=4'b0100, data_in[2]=16'h00A5, buf_ready=1.
  - Response: gnt=4'b0100 from cycle 1; wr_en=1 at cycle 2 with wr_addr=0, wr_data=16'h00A5; stall[2]=1 in cycles 0-1, 0 in cycle 2.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously.
  - Response: grant order 0,1,2,3,0; wr_addr 0..4. Under OWA_FIXED_PRIORITY_EN, writer 0 wins every time.
- Backpressure:
  - Stimulus: req=4'b0001, buf_ready=0 for 5 cycles, then 1.
  - Response: state holds WAIT_RDY with gnt=4'b0001 and wr_en=0; single write one cycle after buf_ready rises.
- Full:
  - Stimulus: DEPTH=4, 5 requests.
  - Response: 4 writes at addr 0-3; buf_full=1 after the 4th; 5th request gets no gnt; clr then gives buf_full=0 and the next write at addr 0.
- clr during WRITE:
  - Stimulus: assert clr in the WRITE cycle.
  - Response: wr_en=0, count stays 0, state=IDLE next cycle.
- Reset mid-WAIT_RDY:
  - Stimulus: rst_n=0 for one cycle while in WAIT_RDY.
  - Response: all outputs at reset values next cycle; no write issued.

Source files
------------

// File: rtl/output_write_arbiter_if.sv
// output_write_arbiter_if: writer/buffer-side bundle of the output write arbiter.
// master = the PE-side writers plus the output buffer, slave = the arbiter.
//
// Handshake: req[i] is writer i's "valid". Once raised, it stays high with
// data_in stable until the writer sees wr_en=1 with gnt[i]=1, which marks the
// write cycle. buf_ready is the buffer's "ready". It is sampled only while the
// arbiter is choosing a writer or waiting for the buffer. A write happens in
// exactly the cycle where wr_en=1, at wr_addr with wr_data.
interface output_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic                      buf_ready;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        stall;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      buf_full;

    modport master (
        output req, data_in, buf_ready,
        input  gnt, stall, wr_en, wr_addr, wr_data, buf_full
    );

    modport slave (
        input  req, data_in, buf_ready,
        output gnt, stall, wr_en, wr_addr, wr_data, buf_full
    );
endinterface

// File: rtl/output_write_arbiter.sv
// output_write_arbiter: shares the single output-buffer write port among
// NUM_REQ writers. Grants are round-robin by default. Define
// OWA_FIXED_PRIORITY_EN to make the lowest-index requester win instead; the
// round-robin pointer is then removed.
//
// Each transaction runs IDLE -> ARB -> (WAIT_RDY) -> WRITE -> RELEASE.
// Writes go to an auto-incrementing address until DEPTH words have been written.
// A clr starts a new tile.
// dbg_state encoding: 0 IDLE, 1 ARB, 2 WAIT_RDY, 3 WRITE, 4 RELEASE.
// DEPTH must not exceed 2**ADDR_W.
module output_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output_write_arbiter_if.slave bus,
    output logic [2:0]            dbg_state
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_WRITE    = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] pick;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               buf_full;
    logic               wr_en;
    logic [DATA_W-1:0]  wr_data;

`ifdef OWA_FIXED_PRIORITY_EN
    logic found;

    // Winner selection: the lowest-index active request wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end
`else
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] pick_hi, pick_lo;
    logic               found_hi, found_lo;

    // Winner selection: take the first request above ptr. If there is none,
    // wrap around and take the lowest request.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && (PTR_W'(i) > ptr_q) && !found_hi) begin
                pick_hi[i] = 1'b1;
                found_hi   = 1'b1;
            end
            if (bus.req[i] && !found_lo) begin
                pick_lo[i] = 1'b1;
                found_lo   = 1'b1;
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    // Index of the writer currently holding the one-hot grant.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) gnt_idx = PTR_W'(i);
        end
    end

    // ptr remembers the writer served last. clr keeps it; an aborted write does not move it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PTR_RST;
        end else if (state_q == S_WRITE && !clr) begin
            ptr_q <= gnt_idx;
        end
    end
`endif

    assign buf_full = (count_q == DEPTH_C);

    // State, grant and word count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
        end
    end

    // Next state, next grant, next count and the write strobe. clr overrides everything.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|bus.req) && !buf_full) begin
                    state_d = S_ARB;
                    gnt_d   = pick;
                end
            end
            S_ARB: begin
                if (!(|bus.req)) begin
                    // Every writer withdrew before the decision was made.
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    gnt_d   = pick;
                    state_d = bus.buf_ready ? S_WRITE : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (bus.buf_ready) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                count_d = count_q + 1'b1;
                gnt_d   = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Dead cycle that lets the served writer drop its request.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (clr) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            count_d = '0;
            wr_en   = 1'b0;
        end
    end

    // Write data is selected from the granted writer's lane.
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) wr_data = wr_data | bus.data_in[i*DATA_W +: DATA_W];
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = count_q[ADDR_W-1:0];
    assign bus.wr_data  = wr_data;
    assign bus.buf_full = buf_full;
    // A requester stalls unless this is its write cycle. When the tile is
    // cleared or full, writers are released and no stall is shown.
    assign bus.stall    = bus.req
                        & ~({NUM_REQ{state_q == S_WRITE}} & gnt_q)
                        & {NUM_REQ{!(clr || buf_full)}};
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_output_write_arbiter.sv
// tb_output_write_arbiter: randomized and directed bench for output_write_arbiter.
// Expected writes are queued when requests are issued. A monitor pops and
// compares them whenever wr_en is seen.
module tb_output_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int DEPTH   = 4;
    localparam int EW      = NUM_REQ + ADDR_W + DATA_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      clr;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic                      buf_ready;
    logic [2:0]                dbg_state;

    output_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    assign bus.req       = req;
    assign bus.data_in   = data_in;
    assign bus.buf_ready = buf_ready;

    output_write_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard and reference model state
    logic [EW-1:0] exp_q[$];
    int            m_count;
    int            m_last;
    int            served_cnt[NUM_REQ];
    int            seen_cnt[NUM_REQ];
    int            n_vec;
    int            n_fail;
    bit            rdy_rand;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // The next writer served out of the set still requesting.
    function automatic int next_winner(input logic [NUM_REQ-1:0] mask, input int last);
`ifdef OWA_FIXED_PRIORITY_EN
        for (int i = 0; i < NUM_REQ; i++) if (mask[i]) return i;
`else
        for (int k = 1; k <= NUM_REQ; k++) if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
        return 0;
    endfunction

    // Queue the writes for one round. Every writer in the mask holds its
    // request until it is served, then drops it.
    task automatic expect_round(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] left;
        logic [NUM_REQ-1:0] g;
        int                 w;
        left = mask;
        while (left != '0) begin
            w = next_winner(left, m_last);
            g = '0;
            g[w] = 1'b1;
            exp_q.push_back({g, ADDR_W'(m_count), data_in[w*DATA_W +: DATA_W]});
            m_count++;
            m_last  = w;
            left[w] = 1'b0;
        end
    endtask

    // Advance one cycle. Writers that were just served drop their requests.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (served_cnt[i] != seen_cnt[i]) begin
                req[i]      = 1'b0;
                seen_cnt[i] = served_cnt[i];
            end
        end
        if (rdy_rand) buf_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_random_data();
        for (int i = 0; i < NUM_REQ; i++) data_in[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic pulse_clr();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_count = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((req != '0 || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drain"}, {31'd0, (req != '0 || exp_q.size() != 0)}, 32'd0);
        if (req != '0) req = '0;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        check({name, "_gnt"},     bus.gnt,      '0);
        check({name, "_wr_en"},   bus.wr_en,    '0);
        check({name, "_wr_addr"}, bus.wr_addr,  '0);
        check({name, "_wr_data"}, bus.wr_data,  '0);
        check({name, "_full"},    bus.buf_full, '0);
        check({name, "_stall"},   bus.stall,    '0);
        check({name, "_state"},   dbg_state,    ST_IDLE);
    endtask

    // monitor: on every write, pop the expected entry and compare
    task automatic monitor();
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                got = {bus.gnt, bus.wr_addr, bus.wr_data};
                for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) served_cnt[i]++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %0h, expected no write", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("write", got, exp);
                end
            end
        end
    endtask

    initial begin
        logic [NUM_REQ-1:0] mask;
        rst_n = 1'b0; clr = 1'b0; req = '0; data_in = '0; buf_ready = 1'b0; rdy_rand = 1'b0;
        m_count = 0; m_last = NUM_REQ - 1; n_vec = 0; n_fail = 0;
        for (int i = 0; i < NUM_REQ; i++) begin served_cnt[i] = 0; seen_cnt[i] = 0; end
        fork monitor(); join_none

        // reset for two cycles
        repeat (2) tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // single request: grant one cycle later, write two cycles later
        tick();
        req = 4'b0100; data_in[2*DATA_W +: DATA_W] = 16'h00A5; buf_ready = 1'b1;
        expect_round(4'b0100);
        @(negedge clk);
        check("single_c0_stall", bus.stall, 4'b0100);
        check("single_c0_gnt",   bus.gnt,   4'b0000);
        tick(); @(negedge clk);
        check("single_c1_gnt",   bus.gnt,   4'b0100);
        check("single_c1_stall", bus.stall, 4'b0100);
        check("single_c1_wr_en", bus.wr_en, 1'b0);
        tick(); @(negedge clk);
        check("single_c2_wr_en", bus.wr_en,   1'b1);
        check("single_c2_addr",  bus.wr_addr, 3'd0);
        check("single_c2_data",  bus.wr_data, 16'h00A5);
        check("single_c2_stall", bus.stall,   4'b0000);
        wait_done("single");

        // fill the tile, then a fifth request must wait for clr
        pulse_clr();
        @(negedge clk);
        check("clr_full", bus.buf_full, 1'b0);
        tick();
        req = 4'b1111; set_random_data();
        expect_round(4'b1111);
        wait_done("fill");
        @(negedge clk);
        check("full_flag", bus.buf_full, 1'b1);
        tick();
        req = 4'b0001; set_random_data();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("full_no_gnt",   bus.gnt,   4'b0000);
            check("full_no_stall", bus.stall, 4'b0000);
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0; m_count = 0;
        expect_round(4'b0001);
        @(negedge clk);
        check("after_clr_full", bus.buf_full, 1'b0);
        wait_done("after_full");

        // backpressure: buf_ready low for five cycles
        tick();
        req = 4'b0001; buf_ready = 1'b0; set_random_data();
        expect_round(4'b0001);
        for (int c = 1; c <= 4; c++) begin
            tick(); @(negedge clk);
            if (c >= 2) begin
                check("bp_state", dbg_state, ST_WAIT);
                check("bp_gnt",   bus.gnt,   4'b0001);
                check("bp_wr_en", bus.wr_en, 1'b0);
            end
        end
        tick(); buf_ready = 1'b1; @(negedge clk);
        check("bp_rise_wr_en", bus.wr_en, 1'b0);
        tick(); @(negedge clk);
        check("bp_write", bus.wr_en, 1'b1);
        wait_done("bp");

        // clr during the WRITE cycle
        pulse_clr();
        tick();
        req = 4'b0010; buf_ready = 1'b1; set_random_data();
        tick();
        tick(); clr = 1'b1; @(negedge clk);
        check("clrw_state", dbg_state, ST_WRITE);
        check("clrw_wr_en", bus.wr_en, 1'b0);
        check("clrw_stall", bus.stall, 4'b0000);
        tick(); clr = 1'b0; @(negedge clk);
        check("clrw_idle", dbg_state,   ST_IDLE);
        check("clrw_addr", bus.wr_addr, 3'd0);
        check("clrw_gnt",  bus.gnt,     4'b0000);
        m_count = 0;
        expect_round(4'b0010);
        wait_done("clrw");

        // reset while in WAIT_RDY
        tick();
        req = 4'b0100; buf_ready = 1'b0; set_random_data();
        tick(); tick(); @(negedge clk);
        check("rstw_state", dbg_state, ST_WAIT);
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; req = '0; buf_ready = 1'b1;
        m_count = 0; m_last = NUM_REQ - 1;
        check_reset_outputs("rst_wait");
        repeat (4) tick();

        // all writers at once from a fresh pointer
        tick();
        req = 4'b1111; set_random_data();
        expect_round(4'b1111);
        wait_done("rr_fresh");

        // random rounds with a random buffer-ready pattern
        for (int r = 0; r < 60; r++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            rdy_rand = ($urandom_range(0, 1) == 1);
            if (!rdy_rand) buf_ready = 1'b1;
            if (m_count + $countones(mask) > DEPTH) pulse_clr();
            repeat ($urandom_range(0, 2)) tick();
            tick();
            req = mask; set_random_data();
            expect_round(mask);
            wait_done("random");
        end

        rdy_rand = 1'b0;
        repeat (4) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
